alu_pipe_param: RTL

- Parametrised, pipelined signed ALU; successor to the 4-bit single-register adder/function-select block.
- Operands are W-bit two's complement. Eight functions, status flags, LED indicator.
- Optional sign-magnitude output conversion.
- valid/ready handshake on both sides, so it can sit between an input-switch sampler and a seven-seg/LED display stage.

---
 rtl/alu_pipe_param.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_pipe_param.sv
// Two-stage pipelined signed ALU with flags, LED indicator and
// optional sign-magnitude presentation of add/sub results.
module alu_pipe_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sm_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_ovf,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             out_led
);

  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic             v1_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       f_q;
  logic             sm_q;
  logic             adv;

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] dif_d;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] neg_d;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d;
  logic             led_d;
  logic             arith_d;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    sum_d = a_q + b_q;
    dif_d = a_q - b_q;
    t_d   = '0;
    ovf_d = 1'b0;
    unique case (f_q)
      3'b000: begin
        t_d   = sum_d;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                (sum_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b001: begin
        t_d   = dif_d;
        ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                (dif_d[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b010: t_d = ~a_q;
      3'b011: t_d = a_q & b_q;
      3'b100: t_d = a_q | b_q;
      3'b101: t_d = a_q ^ b_q;
      // true signed compare, immune to a-b wraparound
      3'b110: t_d = {{(WIDTH-1){1'b0}},
                     $signed(a_q) < $signed(b_q)};
      3'b111: t_d = {{(WIDTH-1){1'b0}}, a_q == b_q};
    endcase

    arith_d = (f_q[2:1] == 2'b00);
    neg_d   = -t_d;
    res_d   = t_d;
    if (sm_q && arith_d && t_d[WIDTH-1]) begin
      if (t_d == MINV) begin
        res_d = '1;
        ovf_d = 1'b1;
      end else begin
        res_d = {1'b1, neg_d[WIDTH-2:0]};
      end
    end

    if (arith_d)
      led_d = t_d[WIDTH-1];
    else if (f_q[2:1] == 2'b11)
      led_d = t_d[0];
    else
      led_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flag_ovf  <= 1'b0;
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
      out_led   <= 1'b0;
    end else if (adv) begin
      v1_q      <= in_valid;
      out_valid <= v1_q;
      if (v1_q) begin
        result    <= res_d;
        flag_ovf  <= ovf_d;
        flag_zero <= (t_d == '0);
        flag_neg  <= t_d[WIDTH-1];
        out_led   <= led_d;
      end
    end
  end

  // operand capture needs no reset: v1_q qualifies it
  always_ff @(posedge clk) begin
    if (in_valid && adv) begin
      a_q  <= a;
      b_q  <= b;
      f_q  <= func;
      sm_q <= sm_mode;
    end
  end

endmodule
